// File: rtl/memshare_seq_ctrl_mc.sv
// Multi-port L1PA shift-sequence controller: each port accepts a request flag and walks a
// linked chain of {last, next, shift} pages held in a shared, programmable register file.
module memshare_seq_ctrl_mc #(
  parameter int unsigned SHARE_GROUP_SIZE = 5,
  parameter int unsigned NUM_PORT         = 2,
  parameter int unsigned SEQ_SIZE         = 4,
  parameter int unsigned SHIFT_BW         = $clog2(SHARE_GROUP_SIZE),
  parameter int unsigned ADDR_W           = SHARE_GROUP_SIZE,
  parameter int unsigned PAGE_W           = 1 + ADDR_W + SHIFT_BW,
  parameter bit          BYPASS_ZERO      = 1'b1
) (
  input  logic                         sys_clk,
  input  logic                         rstn,
  input  logic [NUM_PORT*ADDR_W-1:0]   rqst_flag_i,
  input  logic [NUM_PORT-1:0]          rqst_valid_i,
  output logic [NUM_PORT-1:0]          rqst_ready_o,
  output logic [NUM_PORT*SHIFT_BW-1:0] l1pa_shift_o,
  output logic [NUM_PORT-1:0]          isGtr_o,
  output logic [NUM_PORT-1:0]          shift_valid_o,
  input  logic [NUM_PORT-1:0]          shift_ready_i,
  output logic [NUM_PORT-1:0]          seq_err_o,
  input  logic [ADDR_W-1:0]            regType0_waddr_i,
  input  logic [PAGE_W-1:0]            regType0_wdata_i,
  input  logic                         regType0_we_i
);

  localparam int unsigned PAGE_NUM = 1 << ADDR_W;
  localparam int unsigned STEP_W   = $clog2(SEQ_SIZE + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SEQ_SIZE);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef struct packed {
    logic                last;
    logic [ADDR_W-1:0]   next;
    logic [SHIFT_BW-1:0] shift;
  } page_t;

  // Reset page doubles as the bypass beat for a zero flag: one shift-0 beat, last set.
  localparam page_t DFLT_PAGE = '{last: 1'b1, next: '0, shift: '0};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  page_t pages_q [PAGE_NUM];

  // Shared page register file; reads elsewhere see the pre-write contents in the write cycle.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(PAGE_NUM); i++) pages_q[i] <= DFLT_PAGE;
    end else if (regType0_we_i) begin
      pages_q[regType0_waddr_i] <= page_t'(regType0_wdata_i);
    end
  end

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    state_t              state_q, state_d;
    logic [SHIFT_BW-1:0] shift_q, shift_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   next_q, next_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   flag;
    logic                ready_c, beat_done, ld_en;
    page_t               ld_page;
    logic [STEP_W-1:0]   ld_step;

    assign flag      = rqst_flag_i[p*ADDR_W +: ADDR_W];
    assign beat_done = valid_q & shift_ready_i[p];
    assign ready_c   = (state_q == IDLE) | ((state_q == BUSY) & beat_done & last_q);

    // Next-state: accept/reload, advance along next pointers, or retire to IDLE.
    always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      last_d  = last_q;
      next_d  = next_q;
      step_d  = step_q;
      valid_d = valid_q;
      err_d   = err_q;
      ld_en   = 1'b0;
      ld_page = pages_q[next_q];
      ld_step = (step_q == STEP_MAX) ? step_q : step_q + STEP_ONE;

      if (rqst_valid_i[p] && ready_c) begin
        ld_en   = 1'b1;
        ld_step = STEP_ONE;
        ld_page = (BYPASS_ZERO && (flag == '0)) ? DFLT_PAGE : pages_q[flag];
      end else if ((state_q == BUSY) && beat_done) begin
        if (last_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          ld_en = 1'b1;
        end
      end

      if (ld_en) begin
        state_d = BUSY;
        valid_d = 1'b1;
        shift_d = ld_page.shift;
        next_d  = ld_page.next;
        step_d  = ld_step;
        last_d  = ld_page.last;
        // Length guard: cut the chain at SEQ_SIZE beats so cyclic pointers cannot hang.
        if ((ld_step == STEP_MAX) && !ld_page.last) begin
          last_d = 1'b1;
          err_d  = 1'b1;
        end
      end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        shift_q <= '0;
        last_q  <= 1'b0;
        next_q  <= '0;
        step_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        shift_q <= shift_d;
        last_q  <= last_d;
        next_q  <= next_d;
        step_q  <= step_d;
        valid_q <= valid_d;
        err_q   <= err_d;
      end
    end

    assign rqst_ready_o[p]                      = ready_c;
    assign l1pa_shift_o[p*SHIFT_BW +: SHIFT_BW] = shift_q;
    assign isGtr_o[p]                           = last_q;
    assign shift_valid_o[p]                     = valid_q;
    assign seq_err_o[p]                         = err_q;
  end

endmodule

// File: tb/tb_memshare_seq_ctrl_mc.sv
// Bench for memshare_seq_ctrl_mc: directed scenarios plus randomized traffic, checked against
// a per-port queue of expected beats built from the page chain at request acceptance.
module tb_memshare_seq_ctrl_mc;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned SB = 3;
  localparam int unsigned PW = 9;
  localparam int unsigned SEQ = 4;

  logic             sys_clk = 1'b0;
  logic             rstn = 1'b1;
  logic [NP*AW-1:0] rqst_flag_i = '0;
  logic [NP-1:0]    rqst_valid_i = '0;
  logic [NP-1:0]    rqst_ready_o;
  logic [NP*SB-1:0] l1pa_shift_o;
  logic [NP-1:0]    isGtr_o;
  logic [NP-1:0]    shift_valid_o;
  logic [NP-1:0]    shift_ready_i = '1;
  logic [NP-1:0]    seq_err_o;
  logic [AW-1:0]    regType0_waddr_i = '0;
  logic [PW-1:0]    regType0_wdata_i = '0;
  logic             regType0_we_i = 1'b0;

  always #5 sys_clk = ~sys_clk;

  memshare_seq_ctrl_mc dut (
    .sys_clk          (sys_clk),
    .rstn             (rstn),
    .rqst_flag_i      (rqst_flag_i),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_ready_o     (rqst_ready_o),
    .l1pa_shift_o     (l1pa_shift_o),
    .isGtr_o          (isGtr_o),
    .shift_valid_o    (shift_valid_o),
    .shift_ready_i    (shift_ready_i),
    .seq_err_o        (seq_err_o),
    .regType0_waddr_i (regType0_waddr_i),
    .regType0_wdata_i (regType0_wdata_i),
    .regType0_we_i    (regType0_we_i)
  );

  typedef struct packed {
    logic [SB-1:0] shift;
    logic          last;
    logic          trunc;
  } beat_t;

  beat_t         exp_q [NP][$];
  logic [PW-1:0] mem [32];
  logic [NP-1:0] err_exp;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] page(input logic last, input logic [AW-1:0] nxt,
                                         input logic [SB-1:0] sh);
    return {last, nxt, sh};
  endfunction

  // Expected beats of one request: follow next pointers until last, at most SEQ beats.
  function automatic void build(input int p, input logic [AW-1:0] flag);
    logic [AW-1:0] a;
    logic [PW-1:0] pg;
    beat_t         b;
    if (flag == '0) begin
      b = '{shift: '0, last: 1'b1, trunc: 1'b0};
      exp_q[p].push_back(b);
      return;
    end
    a = flag;
    for (int k = 1; k <= int'(SEQ); k++) begin
      pg      = mem[a];
      b.shift = pg[SB-1:0];
      b.trunc = (k == int'(SEQ)) && !pg[PW-1];
      b.last  = pg[PW-1] || (k == int'(SEQ));
      exp_q[p].push_back(b);
      if (b.last) break;
      a = pg[PW-2:SB];
    end
  endfunction

  // Called at a negedge with inputs already set: check outputs, then advance the model one edge.
  task automatic cycle();
    logic [NP-1:0] rdy_exp;
    beat_t         b;
    #1;
    for (int p = 0; p < int'(NP); p++) begin
      rdy_exp[p] = (exp_q[p].size() == 0) || (exp_q[p].size() == 1 && shift_ready_i[p]);
      check($sformatf("p%0d_ready", p), 32'(rqst_ready_o[p]), 32'(rdy_exp[p]));
      check($sformatf("p%0d_valid", p), 32'(shift_valid_o[p]), 32'(exp_q[p].size() != 0));
      if (exp_q[p].size() != 0) begin
        check($sformatf("p%0d_shift", p), 32'(l1pa_shift_o[p*SB +: SB]), 32'(exp_q[p][0].shift));
        check($sformatf("p%0d_isGtr", p), 32'(isGtr_o[p]), 32'(exp_q[p][0].last));
        check($sformatf("p%0d_err", p), 32'(seq_err_o[p]), 32'(err_exp[p] | exp_q[p][0].trunc));
      end else begin
        check($sformatf("p%0d_err", p), 32'(seq_err_o[p]), 32'(err_exp[p]));
      end
    end
    @(posedge sys_clk);
    for (int p = 0; p < int'(NP); p++) begin
      if (exp_q[p].size() != 0 && shift_ready_i[p]) begin
        b = exp_q[p].pop_front();
        if (b.trunc) err_exp[p] = 1'b1;
      end
      if (rqst_valid_i[p] && rdy_exp[p]) build(p, rqst_flag_i[p*AW +: AW]);
    end
    if (regType0_we_i) mem[regType0_waddr_i] = regType0_wdata_i;
    @(negedge sys_clk);
  endtask

  task automatic req(input int p, input logic v, input logic [AW-1:0] f);
    rqst_valid_i[p]        = v;
    rqst_flag_i[p*AW +: AW] = f;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
    regType0_we_i    = 1'b1;
    regType0_waddr_i = a;
    regType0_wdata_i = d;
    cycle();
    regType0_we_i = 1'b0;
  endtask

  task automatic drain();
    rqst_valid_i  = '0;
    shift_ready_i = '1;
    regType0_we_i = 1'b0;
    for (int i = 0; i < 20 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) cycle();
    check("drain_done", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
  endtask

  // Asynchronous reset pulse issued at a negedge; outputs must clear without a clock edge.
  task automatic do_reset();
    rqst_valid_i  = '0;
    regType0_we_i = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_valid", 32'(shift_valid_o), 32'd0);
    check("rst_ready", 32'(rqst_ready_o), 32'(2'b11));
    check("rst_err",   32'(seq_err_o), 32'd0);
    check("rst_shift", 32'(l1pa_shift_o), 32'd0);
    check("rst_isGtr", 32'(isGtr_o), 32'd0);
    for (int p = 0; p < int'(NP); p++) exp_q[p].delete();
    for (int i = 0; i < 32; i++) mem[i] = page(1'b1, '0, '0);
    err_exp = '0;
    @(negedge sys_clk);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge sys_clk);
    do_reset();
    cycle();

    // Two-page chain 3 -> 7 with free-flowing downstream.
    wr(5'd3, page(1'b0, 5'd7, 3'd2));
    wr(5'd7, page(1'b1, 5'd0, 3'd4));
    req(0, 1'b1, 5'd3);
    cycle();
    req(0, 1'b0, 5'd0);
    repeat (3) cycle();
    drain();

    // Downstream stall on the first beat.
    req(0, 1'b1, 5'd3);
    cycle();
    req(0, 1'b0, 5'd0);
    shift_ready_i[0] = 1'b0;
    repeat (3) cycle();
    shift_ready_i[0] = 1'b1;
    drain();

    // Self-looping page is cut at the length limit; the error flag is sticky.
    wr(5'd5, page(1'b0, 5'd5, 3'd1));
    req(0, 1'b1, 5'd5);
    cycle();
    req(0, 1'b0, 5'd0);
    drain();
    repeat (2) cycle();
    check("err_sticky", 32'(seq_err_o[0]), 32'd1);

    // Both ports launched together.
    req(0, 1'b1, 5'd3);
    req(1, 1'b1, 5'd7);
    cycle();
    req(0, 1'b0, 5'd0);
    req(1, 1'b0, 5'd0);
    drain();

    // Back-to-back single-beat requests, then zero-flag bypass with page 0 programmed.
    wr(5'd0, page(1'b0, 5'd3, 3'd5));
    req(0, 1'b1, 5'd7);
    repeat (5) cycle();
    req(0, 1'b1, 5'd0);
    repeat (3) cycle();
    drain();

    // Rewrite page 3 while its beat is on the output; the next request sees the new page.
    req(0, 1'b1, 5'd3);
    cycle();
    req(0, 1'b0, 5'd0);
    wr(5'd3, page(1'b1, 5'd0, 3'd6));
    drain();
    req(0, 1'b1, 5'd3);
    cycle();
    req(0, 1'b0, 5'd0);
    drain();

    // Reset in the middle of a long sequence.
    req(0, 1'b1, 5'd5);
    req(1, 1'b1, 5'd7);
    cycle();
    req(0, 1'b0, 5'd0);
    req(1, 1'b0, 5'd0);
    cycle();
    do_reset();
    drain();

    // Randomized traffic; pages are reprogrammed only while both ports are idle.
    for (int r = 0; r < 8; r++) begin
      drain();
      for (int w = 0; w < 5; w++)
        wr(5'($urandom_range(0, 7)),
           page(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
      for (int c = 0; c < 60; c++) begin
        for (int p = 0; p < int'(NP); p++) begin
          req(p, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)));
          shift_ready_i[p] = ($urandom_range(0, 3) != 0);
        end
        cycle();
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memshare_seq_ctrl_mc.md
Name: memshare_seq_ctrl_mc

Overview:
- Multi-port L1PA shift-sequence controller for the memory-share datapath.
- Each of NUM_PORT requestor channels accepts a share request flag through a valid/ready handshake, then walks a linked shift-pattern sequence held in a shared, programmable register file.
- Emits one L1PA shift control per accepted output beat, with back-pressure and a last-pattern marker.
- Generalises the single-port, fixed-flow request-to-shift pipeline to N channels, handshaked flow control and a bounded-length sequence walk.

Parameters:
- SHARE_GROUP_SIZE, 5: requestors per share group; also the width of a request flag.
- NUM_PORT, 2: independent request/shift channels.
- SEQ_SIZE, 4: maximum patterns per sequence; enforced by the length guard.
- SHIFT_BW, $clog2(SHARE_GROUP_SIZE): width of the L1PA shift field.
- ADDR_W, SHARE_GROUP_SIZE: register-file address width; PAGE_NUM = 2**ADDR_W.
- PAGE_W, 1+ADDR_W+SHIFT_BW: page layout {last, next_addr, shift}.
- BYPASS_ZERO, 1: if 1, a flag of 0 skips the register file.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rqst_flag_i  in  NUM_PORT*ADDR_W  per-port request flag; port p occupies bits [p*ADDR_W +: ADDR_W].
- rqst_valid_i  in  NUM_PORT  per-port request valid.
- rqst_ready_o  out  NUM_PORT  per-port request ready.
- l1pa_shift_o  out  NUM_PORT*SHIFT_BW  per-port shift control.
- isGtr_o  out  NUM_PORT  per-port flag: 1 means the current beat is the last pattern of its sequence.
- shift_valid_o  out  NUM_PORT  per-port output beat valid.
- shift_ready_i  in  NUM_PORT  per-port downstream ready.
- seq_err_o  out  NUM_PORT  sticky per-port error: sequence truncated by the length guard.
- regType0_waddr_i  in  ADDR_W  register-file write address.
- regType0_wdata_i  in  PAGE_W  register-file write data.
- regType0_we_i  in  1  register-file write enable.

Behaviour:
- Reset (asynchronous, rstn=0):
  - All outputs are 0 except rqst_ready_o, which is all-ones.
  - All per-port state is IDLE; seq_err_o is cleared.
  - Every page resets to {last=1, next=0, shift=0}, so an unprogrammed flag yields one shift-0 beat.
- Register file:
  - Single write port; one combinational read per port.
  - A write lands at the clock edge. A same-cycle read of the same address returns the old contents.
  - Writes are legal at any time, including while ports are BUSY.
- Per-port FSM has two states, IDLE and BUSY. Ports are fully independent, with no arbitration.
- Request accept:
  - A request is accepted when rqst_valid_i & rqst_ready_o at the clock edge.
  - rqst_ready_o = (state==IDLE) | (state==BUSY & shift_valid_o & shift_ready_i & isGtr_o). The second term gives back-to-back acceptance with zero bubble.
- Load on accept:
  - Output registers load from page[flag]: shift, last, next.
  - shift_valid_o is asserted the next cycle. Request-to-first-beat latency is 1 cycle.
  - step_cnt is set to 1.
- Advance in BUSY (a beat completes when shift_valid_o & shift_ready_i):
  - If isGtr_o=1: go to IDLE, or reload if a new request is accepted in the same cycle.
  - Otherwise load page[next], step_cnt += 1, and shift_valid_o stays high.
- Stall: while shift_ready_i=0, all of l1pa_shift_o, isGtr_o and shift_valid_o hold stable.
- Length guard:
  - When the page being loaded would make step_cnt==SEQ_SIZE and that page has last=0, force isGtr_o=1 for that beat.
  - seq_err_o[p] is set sticky and is cleared only by reset.
  - Result: a sequence never exceeds SEQ_SIZE beats, and cyclic next-pointers cannot hang the port.
- BYPASS_ZERO=1 with flag==0: emit a single beat {shift=0, isGtr=1} without reading the register file.
- step_cnt width is $clog2(SEQ_SIZE+1) and saturates at SEQ_SIZE.
- Reset asserted mid-sequence: the port returns to IDLE immediately. No partial beat remains valid after rstn rises.

Test Plan:
- Program page 3 = {0,7,2} and page 7 = {1,0,4}; port0 flag=3 with shift_ready=1 -> beats shift=2/isGtr=0 then shift=4/isGtr=1 on consecutive cycles; rqst_ready is high on the last-beat cycle.
- Same sequence with shift_ready_i low for 3 cycles on beat 1 -> shift=2 is held for 4 cycles; the second beat follows; no beat is lost or duplicated.
- Page 5 = {0,5,1} (self-loop), SEQ_SIZE=4, flag=5 -> exactly 4 beats of shift=1; the 4th has isGtr=1; seq_err_o[0]=1 and stays set.
- Port0 flag=3 and port1 flag=7 in the same cycle -> port0 emits 2,4; port1 emits 4 (isGtr=1) in cycle 1; no interference between ports.
- Back-to-back: rqst_valid held with flag=7 -> one beat per cycle, each isGtr=1, no bubbles; flag=0 -> single beat shift=0 with no register-file dependency.
- Write page 3 while port0 is BUSY reading page 3 -> current beat keeps the old data; the next request sees the new data. rstn pulse mid-sequence -> all valids are 0 and ready=1 asynchronously.
